// File: rtl/beq_branch_unit.sv
// Execute-stage branch evaluator: ALU, offset sign-extend/shift, branch
// target adder and next-PC select, with every result registered once.
module beq_branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [15:0]      offset,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [3:0]       alu_op,
  input  logic             is_beq,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic             branch_taken,
  output logic [WIDTH-1:0] next_pc
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] alu_comb;
  logic [WIDTH-1:0] offset_shifted;
  logic [WIDTH-1:0] target_comb;
  logic             zero_comb;
  logic             taken_comb;
  logic [WIDTH-1:0] next_pc_comb;
  logic             slt_lt;

  // Signed compare directly on the operands so SLT stays correct when A-B overflows.
  assign slt_lt = $signed(rs_val) < $signed(rt_val);

  // ALU operation select; unknown codes yield zero.
  always_comb begin
    alu_comb = '0;
    case (alu_op)
      OP_AND:  alu_comb = rs_val & rt_val;
      OP_OR:   alu_comb = rs_val | rt_val;
      OP_ADD:  alu_comb = rs_val + rt_val;
      OP_SUB:  alu_comb = rs_val - rt_val;
      OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_NOR:  alu_comb = ~(rs_val | rt_val);
      default: alu_comb = '0;
    endcase
  end

  // Sign-extend and shift by 2 in one step; the top two extended bits fall off.
  assign offset_shifted = {{(WIDTH-18){offset[15]}}, offset, 2'b00};
  assign target_comb    = pc_plus4 + offset_shifted;
  assign zero_comb      = (alu_comb == '0);
  assign taken_comb     = is_beq & zero_comb & in_valid;
  assign next_pc_comb   = taken_comb ? target_comb : pc_plus4;

  // Output registers: reset wins and discards the current cycle's inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      branch_taken  <= 1'b0;
      next_pc       <= '0;
    end else begin
      out_valid     <= in_valid;
      alu_result    <= alu_comb;
      zero          <= zero_comb;
      branch_target <= target_comb;
      branch_taken  <= taken_comb;
      next_pc       <= next_pc_comb;
    end
  end

endmodule

// File: tb/tb_beq_branch_unit.sv
// Directed bench for beq_branch_unit: table of vectors with hand-computed
// results, plus reset sequences around them.
module tb_beq_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc_plus4;
  logic [15:0] offset;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  alu_op;
  logic        is_beq;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [31:0] next_pc;

  int tests_run = 0;
  int tests_failed = 0;

  beq_branch_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .pc_plus4      (pc_plus4),
    .offset        (offset),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .alu_op        (alu_op),
    .is_beq        (is_beq),
    .out_valid     (out_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .next_pc       (next_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] pc;
    logic [15:0] off;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        beq;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_tgt;
    logic        e_taken;
    logic [31:0] e_next;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic e_v,
                           input logic [31:0] e_res, input logic e_zero,
                           input logic [31:0] e_tgt, input logic e_taken,
                           input logic [31:0] e_next);
    cmp(name, "out_valid",     {31'b0, out_valid},    {31'b0, e_v});
    cmp(name, "alu_result",    alu_result,            e_res);
    cmp(name, "zero",          {31'b0, zero},         {31'b0, e_zero});
    cmp(name, "branch_target", branch_target,         e_tgt);
    cmp(name, "branch_taken",  {31'b0, branch_taken}, {31'b0, e_taken});
    cmp(name, "next_pc",       next_pc,               e_next);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] off,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic beq);
    in_valid = v; pc_plus4 = pc; offset = off;
    rs_val = a; rt_val = b; alu_op = op; is_beq = beq;
  endtask

  function automatic vec_t mk(string n, logic v, logic [31:0] pc, logic [15:0] off,
                              logic [31:0] a, logic [31:0] b, logic [3:0] op, logic beq,
                              logic [31:0] r, logic z, logic [31:0] t, logic tk,
                              logic [31:0] np);
    vec_t x;
    x.name = n; x.v = v; x.pc = pc; x.off = off; x.a = a; x.b = b; x.op = op;
    x.beq = beq; x.e_res = r; x.e_zero = z; x.e_tgt = t; x.e_taken = tk; x.e_next = np;
    return x;
  endfunction

  initial begin
    //                 name          v  pc            off       A             B             op       beq  res           z  target        tk next
    vecs[0]  = mk("beq_not_taken", 1, 32'd100,      16'd4,    32'd15,       32'd10,       4'b0110, 1, 32'd5,        0, 32'd116,      0, 32'd100);
    vecs[1]  = mk("beq_taken",     1, 32'd100,      16'd4,    32'd10,       32'd10,       4'b0110, 1, 32'd0,        1, 32'd116,      1, 32'd116);
    vecs[2]  = mk("neg_offset",    1, 32'd100,      16'hFFFC, 32'd7,        32'd7,        4'b0110, 1, 32'd0,        1, 32'd84,       1, 32'd84);
    vecs[3]  = mk("target_wrap",   1, 32'hFFFFFFFC, 16'd2,    32'd7,        32'd7,        4'b0110, 1, 32'd0,        1, 32'd4,        1, 32'd4);
    vecs[4]  = mk("alu_and",       1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b0000, 0, 32'd8,        0, 32'd200,      0, 32'd200);
    vecs[5]  = mk("alu_or",        1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b0001, 0, 32'd14,       0, 32'd200,      0, 32'd200);
    vecs[6]  = mk("alu_add",       1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b0010, 0, 32'd22,       0, 32'd200,      0, 32'd200);
    vecs[7]  = mk("alu_sub",       1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b0110, 0, 32'd2,        0, 32'd200,      0, 32'd200);
    vecs[8]  = mk("alu_nor",       1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b1100, 0, 32'hFFFFFFF1, 0, 32'd200,      0, 32'd200);
    vecs[9]  = mk("slt_ovf_true",  1, 32'd200,      16'd0,    32'h80000000, 32'd1,        4'b0111, 0, 32'd1,        0, 32'd200,      0, 32'd200);
    vecs[10] = mk("slt_ovf_false", 1, 32'd200,      16'd0,    32'd1,        32'h80000000, 4'b0111, 0, 32'd0,        1, 32'd200,      0, 32'd200);
    vecs[11] = mk("slt_plain",     1, 32'd200,      16'd0,    32'd5,        32'd10,       4'b0111, 0, 32'd1,        0, 32'd200,      0, 32'd200);
    vecs[12] = mk("alu_add_wrap",  1, 32'd200,      16'd0,    32'hFFFFFFFF, 32'd2,        4'b0010, 0, 32'd1,        0, 32'd200,      0, 32'd200);
    vecs[13] = mk("op_unsupp",     1, 32'd200,      16'd0,    32'h0000000C, 32'h0000000A, 4'b1111, 0, 32'd0,        1, 32'd200,      0, 32'd200);
    vecs[14] = mk("beq_op_unsupp", 1, 32'd300,      16'd1,    32'd3,        32'd5,        4'b1111, 1, 32'd0,        1, 32'd304,      1, 32'd304);
    vecs[15] = mk("beq_op_add",    1, 32'd300,      16'd1,    32'd3,        32'd3,        4'b0010, 1, 32'd6,        0, 32'd304,      0, 32'd300);
    vecs[16] = mk("invalid_gate",  0, 32'd400,      16'd8,    32'd9,        32'd9,        4'b0110, 1, 32'd0,        1, 32'd432,      0, 32'd400);
    vecs[17] = mk("b2b_taken_a",   1, 32'd500,      16'd1,    32'd3,        32'd3,        4'b0110, 1, 32'd0,        1, 32'd504,      1, 32'd504);
    vecs[18] = mk("b2b_not_taken", 1, 32'd600,      16'd1,    32'd3,        32'd4,        4'b0110, 1, 32'hFFFFFFFF, 0, 32'd604,      0, 32'd600);
    vecs[19] = mk("b2b_taken_b",   1, 32'd700,      16'hFFFF, 32'd0,        32'd0,        4'b0110, 1, 32'd0,        1, 32'd696,      1, 32'd696);

    // Reset held two cycles with nonzero, branch-taking inputs.
    reset = 1'b1;
    drive(1, 32'd100, 16'd4, 32'd10, 32'd10, 4'b0110, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_all("reset_hold", 0, 32'd0, 0, 32'd0, 0, 32'd0);
    end

    // Release reset; same inputs appear one cycle later.
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("reset_release", 1, 32'd0, 1, 32'd116, 1, 32'd116);

    // Table applied back to back, one vector per cycle.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].off, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].beq);
      @(posedge clk); #1;
      check_all(vecs[i].name, vecs[i].v, vecs[i].e_res, vecs[i].e_zero,
                vecs[i].e_tgt, vecs[i].e_taken, vecs[i].e_next);
    end

    // Reset mid-stream discards that cycle's valid input.
    drive(1, 32'd800, 16'd2, 32'd1, 32'd1, 4'b0110, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all("reset_midstream", 0, 32'd0, 0, 32'd0, 0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("after_midstream", 1, 32'd0, 1, 32'd808, 1, 32'd808);

    // Outputs hold nothing stale: idle invalid cycle after a taken branch.
    drive(0, 32'd900, 16'd0, 32'd12, 32'd10, 4'b0000, 0);
    @(posedge clk); #1;
    check_all("idle_after", 0, 32'd8, 0, 32'd900, 0, 32'd900);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
